// File: rtl/cpu_pkg.sv
// Shared core definitions: sequencer state encoding, register-zero and SRAM owner constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEMWAIT  = 2'd1,
    EXCFLUSH = 2'd2
  } hz_state_e;

  localparam logic [3:0] REG_ZERO = 4'd0;
  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_MEM  = 1'b1;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the ID sources and the EX load destination.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       ex_memread_i,
  input  logic [3:0] ex_regdst_i,
  input  logic [3:0] id_regsrc1_i,
  input  logic [3:0] id_regsrc2_i,
  input  logic       id_use1_i,
  input  logic       id_use2_i,
  output logic       hazard_o
);

  logic hit1, hit2;

  assign hit1     = id_use1_i && (id_regsrc1_i == ex_regdst_i);
  assign hit2     = id_use2_i && (id_regsrc2_i == ex_regdst_i);
  // r0 is hardwired, so a load targeting it can never feed a consumer
  assign hazard_o = ex_memread_i && (ex_regdst_i != REG_ZERO) && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch/exception flushes, shared SRAM arbitration.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT      = 2,
  parameter int EXC_FLUSH_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] id_regsrc1_i,
  input  logic [3:0] id_regsrc2_i,
  input  logic       id_use1_i,
  input  logic       id_use2_i,
  input  logic       ex_memread_i,
  input  logic [3:0] ex_regdst_i,
  input  logic       mem_req_i,
  input  logic       branch_taken_i,
  input  logic       exception_i,
  output logic       stall_pc_o,
  output logic       stall_if_id_o,
  output logic       flush_if_id_o,
  output logic       flush_id_o,
  output logic       stall_mem_o,
  output logic       sram_owner_o,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] perf_stall_o,
  output logic [15:0] perf_flush_o
`endif
);

  localparam logic [3:0] MW_LOAD  = 4'(MEM_WAIT - 1);
  localparam logic [3:0] EXC_LOAD = 4'(EXC_FLUSH_CYC - 1);

  hz_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       hazard;
  logic       stall_pc, stall_if_id, flush_if_id, flush_id, stall_mem, owner;

  hazard_detect u_detect (
    .ex_memread_i (ex_memread_i),
    .ex_regdst_i  (ex_regdst_i),
    .id_regsrc1_i (id_regsrc1_i),
    .id_regsrc2_i (id_regsrc2_i),
    .id_use1_i    (id_use1_i),
    .id_use2_i    (id_use2_i),
    .hazard_o     (hazard)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id    = 1'b0;
    stall_mem   = 1'b0;
    owner       = OWN_IF;
    case (state_q)
      RUN: begin
        if (exception_i || pend_q) begin
          flush_if_id = 1'b1;
          flush_id    = 1'b1;
          pend_d      = 1'b0;
          if (EXC_FLUSH_CYC > 1) begin
            state_d = EXCFLUSH;
            cnt_d   = EXC_LOAD;
          end
        end else if (mem_req_i) begin
          owner       = OWN_MEM;
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          // a one-cycle access completes inside this grant
          if (MEM_WAIT > 1) begin
            state_d = MEMWAIT;
            cnt_d   = MW_LOAD;
          end
        end else if (hazard) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id    = 1'b1;
        end else if (branch_taken_i) begin
          flush_if_id = 1'b1;
        end
      end
      MEMWAIT: begin
        owner       = OWN_MEM;
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        stall_mem   = 1'b1;
        cnt_d       = cnt_q - 4'd1;
        // the access is never aborted; the exception waits for RUN
        if (exception_i) pend_d = 1'b1;
        if (cnt_d == 4'd0) state_d = RUN;
      end
      EXCFLUSH: begin
        flush_if_id = 1'b1;
        flush_id    = 1'b1;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Mealy outputs are forced low while reset is held
  assign stall_pc_o    = RST & stall_pc;
  assign stall_if_id_o = RST & stall_if_id;
  assign flush_if_id_o = RST & flush_if_id;
  assign flush_id_o    = RST & flush_id;
  assign stall_mem_o   = RST & stall_mem;
  assign sram_owner_o  = RST & owner;
  assign state_o       = state_q;

  always_ff @(posedge CLK) begin
    if (RST) assert (MEM_WAIT >= 1 && MEM_WAIT <= 15 && EXC_FLUSH_CYC >= 1 && EXC_FLUSH_CYC <= 15);
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_pc_o && perf_stall_q != 16'hFFFF) perf_stall_d = perf_stall_q + 16'd1;
    if (flush_id_o && perf_flush_q != 16'hFFFF) perf_flush_d = perf_flush_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_stall_q <= 16'd0;
      perf_flush_q <= 16'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_WAIT=2, EXC_FLUSH_CYC=2) with an expected-output queue.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] id_regsrc1_i, id_regsrc2_i, ex_regdst_i;
  logic       id_use1_i, id_use2_i, ex_memread_i, mem_req_i, branch_taken_i, exception_i;
  logic       stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_o, stall_mem_o, sram_owner_o;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_o, perf_flush_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  hazard_ctrl #(.MEM_WAIT(2), .EXC_FLUSH_CYC(2)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .id_regsrc1_i   (id_regsrc1_i),
    .id_regsrc2_i   (id_regsrc2_i),
    .id_use1_i      (id_use1_i),
    .id_use2_i      (id_use2_i),
    .ex_memread_i   (ex_memread_i),
    .ex_regdst_i    (ex_regdst_i),
    .mem_req_i      (mem_req_i),
    .branch_taken_i (branch_taken_i),
    .exception_i    (exception_i),
    .stall_pc_o     (stall_pc_o),
    .stall_if_id_o  (stall_if_id_o),
    .flush_if_id_o  (flush_if_id_o),
    .flush_id_o     (flush_id_o),
    .stall_mem_o    (stall_mem_o),
    .sram_owner_o   (sram_owner_o),
    .state_o        (state_o)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_o   (perf_stall_o),
    .perf_flush_o   (perf_flush_o)
`endif
  );

  always #5 CLK = ~CLK;

  // {state, owner, stall_mem, flush_id, flush_if_id, stall_if_id, stall_pc}
  function automatic logic [7:0] ev(input logic [1:0] st, input logic own, input logic sm,
                                    input logic fid, input logic fif, input logic sif,
                                    input logic spc);
    return {st, own, sm, fid, fif, sif, spc};
  endfunction

  function automatic logic [7:0] obs();
    return {state_o, sram_owner_o, stall_mem_o, flush_id_o, flush_if_id_o, stall_if_id_o, stall_pc_o};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // inputs are already driven; sample mid-cycle, then advance past the next edge
  task automatic tick(input string tag);
    logic [7:0] e;
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty expected=queued", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {8'h0, obs()}, {8'h0, e});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    id_regsrc1_i = 0; id_regsrc2_i = 0; ex_regdst_i = 0;
    id_use1_i = 0; id_use2_i = 0; ex_memread_i = 0;
    mem_req_i = 0; branch_taken_i = 0; exception_i = 0;
  endtask

  task automatic load_use(input logic [3:0] r);
    ex_memread_i = 1; ex_regdst_i = r; id_regsrc1_i = r; id_use1_i = 1;
  endtask

  initial begin
    clr();
    RST = 1'b0;
    #3;
    chk("reset_outputs", {8'h0, obs()}, 16'h0000);
`ifdef HAZARD_PERF_EN
    chk("reset_perf", {perf_stall_o[7:0], perf_flush_o[7:0]}, 16'h0000);
`endif
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;

    // load-use on src1, then cleared
    load_use(4'd3);
    exp_q.push_back(ev(0,0,0,1,0,1,1)); tick("loaduse_src1");
    clr();
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("loaduse_after");
    // destination r0 never stalls
    load_use(4'd0);
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("loaduse_r0");
    // src2 match
    clr(); ex_memread_i = 1; ex_regdst_i = 5; id_regsrc2_i = 5; id_use2_i = 1;
    exp_q.push_back(ev(0,0,0,1,0,1,1)); tick("loaduse_src2");
    // matching register but not read
    clr(); ex_memread_i = 1; ex_regdst_i = 5; id_regsrc1_i = 5;
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("loaduse_unused");
    // not a load
    clr(); load_use(4'd7); ex_memread_i = 0;
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("loaduse_noload");

    // memory wait, two cycles of ownership
    clr(); mem_req_i = 1;
    exp_q.push_back(ev(0,1,0,0,0,1,1)); tick("memwait_grant");
    mem_req_i = 0;
    exp_q.push_back(ev(1,1,1,0,0,1,1)); tick("memwait_wait");
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("memwait_done");

    // exception during the wait is deferred until RUN
    mem_req_i = 1;
    exp_q.push_back(ev(0,1,0,0,0,1,1)); tick("excmem_grant");
    mem_req_i = 0; exception_i = 1;
    exp_q.push_back(ev(1,1,1,0,0,1,1)); tick("excmem_wait");
    exception_i = 0;
    exp_q.push_back(ev(0,0,0,1,1,0,0)); tick("excmem_pending");
    mem_req_i = 1;  // ignored while flushing
    exp_q.push_back(ev(2,0,0,1,1,0,0)); tick("excmem_flush");
    mem_req_i = 0;
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("excmem_run");

    // exception beats mem request and load-use
    load_use(4'd4); mem_req_i = 1; exception_i = 1;
    exp_q.push_back(ev(0,0,0,1,1,0,0)); tick("simul_exc");
    clr();
    exp_q.push_back(ev(2,0,0,1,1,0,0)); tick("simul_flush");
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("simul_run");

    // mem request beats load-use
    load_use(4'd2); mem_req_i = 1;
    exp_q.push_back(ev(0,1,0,0,0,1,1)); tick("memreq_over_hazard");
    clr();
    exp_q.push_back(ev(1,1,1,0,0,1,1)); tick("memreq_over_hazard_wait");
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("memreq_over_hazard_run");

    // branch vs load-use: stall first, branch next cycle
    load_use(4'd6); branch_taken_i = 1;
    exp_q.push_back(ev(0,0,0,1,0,1,1)); tick("branch_hazard");
    ex_memread_i = 0;
    exp_q.push_back(ev(0,0,0,0,1,0,0)); tick("branch_only");
    clr();
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("branch_clear");

    // asynchronous reset in the middle of a wait
    mem_req_i = 1;
    exp_q.push_back(ev(0,1,0,0,0,1,1)); tick("rstmid_grant");
    #1;
    chk("rstmid_in_wait", {14'h0, state_o}, 16'h0001);
    RST = 1'b0;
    #1;
    chk("rstmid_outputs", {8'h0, obs()}, 16'h0000);
    @(negedge CLK); mem_req_i = 0; RST = 1'b1;
    @(posedge CLK); #1;
    exp_q.push_back(ev(0,0,0,0,0,0,0)); tick("rstmid_after");

`ifdef HAZARD_PERF_EN
    chk("perf_cleared", {perf_stall_o[7:0], perf_flush_o[7:0]}, 16'h0000);
    load_use(4'd9);
    repeat (65540) @(posedge CLK);
    #1;
    chk("perf_stall_sat", perf_stall_o, 16'hFFFF);
    chk("perf_flush_sat", perf_flush_o, 16'hFFFF);
    clr();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 16-bit 5-stage core; sits beside the ID/EX register and drives its flush input plus the PC and IF/ID hold/flush controls.
- Detects load-use hazards and branch/exception redirects.
- Arbitrates the single shared SRAM port between instruction fetch (IF) and data access (MEM), inserting multi-cycle waits.

Parameters:
- MEM_WAIT, 2, SRAM access latency in cycles per data access (1..15).
- EXC_FLUSH_CYC, 2, consecutive cycles of full flush after an exception.

Ports:
- CLK  in  1  core clock, all state on rising edge
- RST  in  1  asynchronous active-low reset
- id_regsrc1_i  in  4  ID-stage source register 1
- id_regsrc2_i  in  4  ID-stage source register 2
- id_use1_i  in  1  ID instruction reads src1
- id_use2_i  in  1  ID instruction reads src2
- ex_memread_i  in  1  EX-stage instruction is a load
- ex_regdst_i  in  4  EX-stage destination register
- mem_req_i  in  1  MEM stage needs SRAM (load or store)
- branch_taken_i  in  1  branch resolved taken in ID
- exception_i  in  1  exception/interrupt raised (EPC already captured)
- stall_pc_o  out  1  hold PC
- stall_if_id_o  out  1  hold IF/ID register
- flush_if_id_o  out  1  load NOP into IF/ID
- flush_id_o  out  1  bubble into ID/EX (drives ID/EX flush_id_i)
- stall_mem_o  out  1  hold EX/MEM and MEM/WB while SRAM busy
- sram_owner_o  out  1  0 = IF owns SRAM, 1 = MEM owns SRAM
- state_o  out  2  current FSM state, debug

Behaviour:
- Reset (RST low, asynchronous): state = RUN, wait counter = 0, all outputs 0, sram_owner_o = 0.
- States (encoding): RUN=0, MEMWAIT=1, EXCFLUSH=2.
- Load-use hazard: ex_memread_i & ex_regdst_i != 0 & ((id_use1_i & id_regsrc1_i == ex_regdst_i) | (id_use2_i & id_regsrc2_i == ex_regdst_i)).
  - Register 0 is never a hazard.
- RUN, cycle-by-cycle priority (highest first):
  1. exception_i: go to EXCFLUSH; counter = EXC_FLUSH_CYC-1; flush_if_id_o = flush_id_o = 1 this cycle.
  2. mem_req_i: go to MEMWAIT; sram_owner_o = 1; counter = MEM_WAIT-1; stall_pc_o = stall_if_id_o = 1; flush_id_o = 0.
     - If MEM_WAIT = 1, a single-cycle grant with no state change.
  3. load-use hazard: stall_pc_o = stall_if_id_o = flush_id_o = 1 for exactly one cycle; stay in RUN.
  4. branch_taken_i: flush_if_id_o = 1 for one cycle; no stall.
  - Branch combined with load-use: the stall wins. The branch is re-evaluated next cycle by ID.
- MEMWAIT:
  - sram_owner_o = 1; stall_pc_o = stall_if_id_o = stall_mem_o = 1.
  - ID/EX is held; flush_id_o = 0.
  - Counter decrements each cycle. At 0, return to RUN with sram_owner_o = 0 in the next cycle.
  - exception_i during MEMWAIT is latched in a pending flag and taken on the first RUN cycle. The access completes; it is never aborted.
- EXCFLUSH:
  - flush_if_id_o = flush_id_o = 1; stall_pc_o = 0 so the handler vector is fetched.
  - Counter decrements; at 0, go to RUN.
  - mem_req_i is ignored, since the flushed stages carry no valid access.
- Outputs are combinational from state and inputs (Mealy). Counter and state are registered.
- Counter width is 4 bits. MEM_WAIT or EXC_FLUSH_CYC = 0 is illegal; an assertion flags it in simulation.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds output perf_stall_o (16 bits): counts cycles with stall_pc_o = 1.
  - Adds output perf_flush_o (16 bits): counts cycles with flush_id_o = 1.
  - Both counters saturate at 16'hFFFF and are cleared by RST.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding constants (RUN/MEMWAIT/EXCFLUSH);
  - REG_ZERO = 4'd0;
  - the SRAM owner constants OWN_IF = 1'b0, OWN_MEM = 1'b1.
- One sub-module, hazard_detect: purely combinational load-use compare, reused by the forwarding unit.
- FSM and counter stay in hazard_ctrl.

Test Plan:
- Load-use: ex_memread_i=1, ex_regdst_i=3, id_regsrc1_i=3, id_use1_i=1 -> one cycle of stall_pc_o=stall_if_id_o=flush_id_o=1, then all 0. Repeat with regdst=0 -> no stall.
- Memory wait, MEM_WAIT=2: pulse mem_req_i -> sram_owner_o=1 and stall_pc_o=1 for 2 cycles; state_o goes 1 then 0; sram_owner_o=0 on cycle 3.
- Exception during MEMWAIT: exception_i=1 in cycle 1 of the wait -> wait completes; next cycle enters EXCFLUSH; flush_id_o=1 for EXC_FLUSH_CYC=2 cycles, with stall_pc_o=0.
- Simultaneous events: exception_i, mem_req_i and the load-use condition in the same RUN cycle -> EXCFLUSH taken, sram_owner_o stays 0.
- Branch vs hazard: branch_taken_i=1 with the load-use condition -> stall only (flush_if_id_o=0); next cycle branch only -> flush_if_id_o=1.
- Async reset mid-MEMWAIT: drop RST -> outputs 0 and state_o=0 immediately, with no clock edge needed. With HAZARD_PERF_EN defined, both counters read 0 and saturate when forced.
